// File: rtl/fft_pkg.sv
// Shared constants, serializer state encoding and the radix-4 digit-reversal map
// used by the FFT output serializer and its frame buffer.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  // Radix-4 butterflies leave bins in base-4 digit-reversed order; swapping the
  // two 2-bit digits maps a natural bin index to its storage slot.
  function automatic logic [IDX_W-1:0] digit_rev(input logic [IDX_W-1:0] i);
    return {i[1:0], i[3:2]};
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Frame store for one FFT frame (re/im per slot) with a digit-reversed read port
// so callers address it by natural-order bin index.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int DATA_W   = fft_pkg::DATA_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic [N_POINTS*DATA_W-1:0]   wr_re_i,
  input  logic [N_POINTS*DATA_W-1:0]   wr_im_i,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic [DATA_W-1:0]            rd_re_o,
  output logic [DATA_W-1:0]            rd_im_o
);

  logic [DATA_W-1:0] re_q [N_POINTS];
  logic [DATA_W-1:0] im_q [N_POINTS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_POINTS; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (wr_en_i) begin
      for (int k = 0; k < N_POINTS; k++) begin
        re_q[k] <= wr_re_i[k*DATA_W +: DATA_W];
        im_q[k] <= wr_im_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_re_o = re_q[digit_rev(rd_idx_i)];
  assign rd_im_o = im_q[digit_rev(rd_idx_i)];

endmodule

// File: rtl/fft_output_serializer.sv
// Captures a parallel FFT frame and streams its bins in natural order over a
// valid/ready handshake. Define FFT_SER_MAG_EN to add the |re|+|im| output out_mag.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int DATA_W   = fft_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_POINTS*DATA_W-1:0]  in_re,
  input  logic [N_POINTS*DATA_W-1:0]  in_im,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [DATA_W-1:0]    out_re,
  output logic signed [DATA_W-1:0]    out_im,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [CNT_W-1:0]            frame_cnt
`ifdef FFT_SER_MAG_EN
  , output logic [DATA_W:0]           out_mag
`endif
);

  ser_state_e               state_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     vld_q;
  logic                     last_q;
  logic signed [DATA_W-1:0] re_q;
  logic signed [DATA_W-1:0] im_q;
  logic [CNT_W-1:0]         cnt_q;

  logic                     hs;
  logic                     last_hs;
  logic                     cap;
  logic [IDX_W-1:0]         nxt_idx_d;
  logic [DATA_W-1:0]        rd_re;
  logic [DATA_W-1:0]        rd_im;
  logic signed [DATA_W-1:0] src_re_d;
  logic signed [DATA_W-1:0] src_im_d;

`ifdef FFT_SER_MAG_EN
  logic [DATA_W:0] mag_q;

  // One extra bit so the most negative sample has a representable magnitude.
  function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] w;
    w = {v[DATA_W-1], v};
    return (w < 0) ? -w : w;
  endfunction
`endif

  assign hs        = vld_q & out_ready;
  assign last_hs   = hs & last_q;
  assign in_ready  = (state_q == IDLE) | last_hs;
  assign cap       = in_valid & in_ready;
  assign nxt_idx_d = idx_q + IDX_W'(1);

  // Bin 0 maps to slot 0, so a fresh frame is presented straight from the input
  // bus while the buffer is being written on the same edge.
  assign src_re_d = cap ? in_re[DATA_W-1:0] : rd_re;
  assign src_im_d = cap ? in_im[DATA_W-1:0] : rd_im;

  fft_frame_buffer #(
    .N_POINTS (N_POINTS),
    .DATA_W   (DATA_W)
  ) u_buf (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_en_i  (cap),
    .wr_re_i  (in_re),
    .wr_im_i  (in_im),
    .rd_idx_i (nxt_idx_d),
    .rd_re_o  (rd_re),
    .rd_im_o  (rd_im)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      cnt_q   <= '0;
`ifdef FFT_SER_MAG_EN
      mag_q   <= '0;
`endif
    end else begin
      if (last_hs) cnt_q <= cnt_q + CNT_W'(1);

      if (cap) begin
        state_q <= STREAM;
        vld_q   <= 1'b1;
        idx_q   <= '0;
        last_q  <= 1'b0;
        re_q    <= src_re_d;
        im_q    <= src_im_d;
`ifdef FFT_SER_MAG_EN
        mag_q   <= abs_ext(src_re_d) + abs_ext(src_im_d);
`endif
      end else if (last_hs) begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
      end else if (hs) begin
        idx_q   <= nxt_idx_d;
        last_q  <= (nxt_idx_d == IDX_W'(N_POINTS-1));
        re_q    <= src_re_d;
        im_q    <= src_im_d;
`ifdef FFT_SER_MAG_EN
        mag_q   <= abs_ext(src_re_d) + abs_ext(src_im_d);
`endif
      end
    end
  end

  assign out_re    = re_q;
  assign out_im    = im_q;
  assign out_index = idx_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;
  assign frame_cnt = cnt_q;
`ifdef FFT_SER_MAG_EN
  assign out_mag   = mag_q;
`endif

endmodule

// File: tb/tb_fft_output_serializer.sv
// Self-checking bench for fft_output_serializer: scoreboard of expected beats
// plus table-driven frames and hand-written stall, back-to-back, reset and wrap cases.
module tb_fft_output_serializer;

  localparam int NP = 16;
  localparam int DW = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NP*DW-1:0]        in_re;
  logic [NP*DW-1:0]        in_im;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    out_re;
  logic signed [DW-1:0]    out_im;
  logic [3:0]              out_index;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [7:0]              frame_cnt;
`ifdef FFT_SER_MAG_EN
  logic [DW:0]             out_mag;
`endif

  always #5 clk = ~clk;

  fft_output_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
`ifdef FFT_SER_MAG_EN
    , .out_mag (out_mag)
`endif
  );

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [3:0]         idx;
    logic               last;
    int                 mag;
  } exp_t;

  typedef struct {
    int rb, rs, ib, is;
    bit rnd;
    int exp_cnt;
  } vec_t;

  exp_t               sb[$];
  logic signed [15:0] slot_re [16];
  logic signed [15:0] slot_im [16];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cap_cyc = 0;
  int last_cyc = 0;

  logic               prev_stall = 1'b0;
  logic signed [15:0] prev_re, prev_im;
  logic [3:0]         prev_idx;
  logic               prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Natural bin i lives in slot (i mod 4)*4 + (i div 4).
  function automatic int brev(input int i);
    return (i % 4) * 4 + (i / 4);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic fill_lin(input int rb, input int rs, input int ib, input int is);
    for (int k = 0; k < 16; k++) begin
      slot_re[k] = 16'(rb + rs * k);
      slot_im[k] = 16'(ib + is * k);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) begin
      slot_re[k] = 16'($urandom);
      slot_im[k] = 16'($urandom);
    end
  endtask

  task automatic send_frame();
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_re[k*16 +: 16] = slot_re[k];
      in_im[k*16 +: 16] = slot_im[k];
    end
    in_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (in_ready) begin
        cap_cyc = cyc;
        for (int i = 0; i < 16; i++) begin
          e.re   = slot_re[brev(i)];
          e.im   = slot_im[brev(i)];
          e.idx  = 4'(i);
          e.last = (i == 15);
          e.mag  = iabs(int'(e.re)) + iabs(int'(e.im));
          sb.push_back(e);
        end
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL capture_timeout actual=no_capture required=capture");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=pending=%0d required=pending=0", sb.size());
    end
  endtask

  task automatic wait_bin(input int b);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_index == 4'(b)) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_bin_timeout actual=not_seen required=bin%0d", b);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_re", out_re, prev_re);
        chk("hold_im", out_im, prev_im);
        chk("hold_idx", out_index, prev_idx);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=idx%0d required=no_beat", out_index);
        end else begin
          e = sb.pop_front();
          chk("beat_re", out_re, e.re);
          chk("beat_im", out_im, e.im);
          chk("beat_idx", out_index, e.idx);
          chk("beat_last", out_last, e.last);
`ifdef FFT_SER_MAG_EN
          chk("beat_mag", out_mag, e.mag);
`endif
          if (out_last) last_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_re    = out_re;
      prev_im    = out_im;
      prev_idx   = out_index;
      prev_last  = out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    tbl[0] = '{rb: 0,      rs: 1,    ib: 0,     is: -1,    rnd: 1'b0, exp_cnt: 1};
    tbl[1] = '{rb: -32768, rs: 4369, ib: 32767, is: -4369, rnd: 1'b0, exp_cnt: 2};
    tbl[2] = '{rb: 4660,   rs: -3,   ib: 5,     is: 7,     rnd: 1'b0, exp_cnt: 3};
    tbl[3] = '{rb: 0,      rs: 0,    ib: 0,     is: 0,     rnd: 1'b1, exp_cnt: 4};

    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_re     = '0;
    in_im     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_index", out_index, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_cnt", frame_cnt, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) begin
      if (tbl[t].rnd) fill_rand();
      else fill_lin(tbl[t].rb, tbl[t].rs, tbl[t].ib, tbl[t].is);
      send_frame();
      drain();
      if (t == 0) chk("last_latency", last_cyc - cap_cyc, 16);
      chk("tbl_frame_cnt", frame_cnt, tbl[t].exp_cnt);
    end

    // Backpressure at bin 5.
    fill_lin(100, 3, -50, -11);
    send_frame();
    wait_bin(5);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_idx", out_index, 5);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drain();
    chk("stall_frame_cnt", frame_cnt, 5);

    // Back-to-back: second frame waits on in_valid through the last handshake.
    fill_lin(7, 11, -3, 13);
    send_frame();
    fill_lin(-200, 17, 300, -19);
    send_frame();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_idx", out_index, 0);
    chk("b2b_re", out_re, -200);
    chk("b2b_cnt_mid", frame_cnt, 6);
    drain();
    chk("b2b_frame_cnt", frame_cnt, 7);

    // Reset mid-frame at bin 7.
    fill_lin(1, 1, 2, 2);
    send_frame();
    wait_bin(7);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_re", out_re, 0);
    chk("mid_rst_im", out_im, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Frame counter wrap.
    for (int f = 0; f < 255; f++) begin
      fill_rand();
      send_frame();
    end
    drain();
    chk("cnt_255", frame_cnt, 255);
    fill_rand();
    send_frame();
    drain();
    chk("cnt_wrap", frame_cnt, 0);

`ifdef FFT_SER_MAG_EN
    fill_lin(0, 1, 0, 1);
    slot_re[0] = -16'sd32768;
    slot_im[0] = 16'sd100;
    send_frame();
    chk("mag_min", out_mag, 32868);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
